// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// parameter limits used by the top level.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Counter must hold WIDTH itself so it never wraps during RUN.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/Gate_FA.sv
// Gate-level 1-bit full adder; the only arithmetic element of the serial
// adder datapath.
module Gate_FA (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic p;
    logic g;
    logic t;

    xor u_x0 (p, a, b);
    xor u_x1 (sum, p, c_in);
    and u_a0 (g, a, b);
    and u_a1 (t, p, c_in);
    or  u_o0 (c_out, g, t);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: adds a + b + c_in one bit per clock, LSB first,
// and publishes {c_out, sum} together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-2:0] acc_d;
    logic [WIDTH-1:0] acc_full;
    logic             fa_sum;
    logic             fa_cout;

    Gate_FA u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // The accumulator keeps only the WIDTH-1 bits already produced; the bit
    // coming out of the adder this cycle completes the full-width result.
    always_comb begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        acc_full = {fa_sum, acc_q};
        acc_d    = acc_full[WIDTH-1:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        acc_q   <= '0;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    acc_q   <= acc_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + ONE;
                    if (cnt_q == LAST) begin
                        sum_q   <= acc_full;
                        c_out_q <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign c_out       = c_out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, reset abort,
// back-to-back throughput and random operands at WIDTH=8, exhaustive at WIDTH=3.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c_out8;
    logic [7:0] sum8;
    logic [1:0] st8;

    logic       start3, cin3;
    logic [2:0] a3, b3;
    logic       busy3, done3, c_out3;
    logic [2:0] sum3;
    logic [1:0] st3;

    logic [8:0] last8;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .dbg_state_o(st8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c_in(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .c_out(c_out3), .dbg_state_o(st3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {c_out, sum} is the exact (WIDTH+1)-bit unsigned sum.
    function automatic logic [8:0] ref8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        return 9'(av) + 9'(bv) + 9'(cv);
    endfunction

    function automatic logic [3:0] ref3(input logic [2:0] av, input logic [2:0] bv, input logic cv);
        return 4'(av) + 4'(bv) + 4'(cv);
    endfunction

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input bit disturb);
        logic [8:0] exp;
        int lat, busy_n, extra_dones;
        bit seen, held_bad;
        exp = ref8(av, bv, cv);
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~av; b8 = ~bv; cin8 = ~cv;
        check("accept_busy", 32'(busy8), 32'd1);
        busy_n = 1; lat = 0; seen = 0; held_bad = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            if (disturb && n == 3) start8 = 1'b1;
            if (disturb && n == 4) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin
                seen = 1; lat = n;
            end else begin
                if (busy8) busy_n++;
                if ({c_out8, sum8} !== last8) held_bad = 1;
            end
        end
        check("done_latency", 32'(lat), 32'd8);
        check("busy_cycles", 32'(busy_n), 32'd8);
        check("result_held", 32'(held_bad), 32'd0);
        check("sum_cout", 32'({c_out8, sum8}), 32'(exp));
        check("busy_at_done", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done8), 32'd0);
        check("back_to_idle", 32'(st8), 32'd0);
        if (disturb) begin
            extra_dones = 0;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk); #1;
                if (done8) extra_dones++;
            end
            check("no_extra_done", 32'(extra_dones), 32'd0);
        end
        last8 = exp;
    endtask

    initial begin
        logic [7:0] bb_a[3];
        logic [7:0] bb_b[3];
        logic       bb_c[3];
        int accepted, dones, last_done, stray;
        bit prev_busy, seen3;
        logic [3:0] exp3;

        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start3 = 0; a3 = 0; b3 = 0; cin3 = 0;
        last8 = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'({c_out8, sum8}), 32'd0);
        check("rst_state", 32'(st8), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // First edge after reset release accepts the start.
        run_op8(8'h00, 8'h00, 1'b0, 0);
        run_op8(8'hFF, 8'h01, 1'b0, 0);
        run_op8(8'h7F, 8'h01, 1'b0, 0);
        run_op8(8'hA5, 8'h5A, 1'b1, 1);

        // Abort mid-RUN with reset.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_sum", 32'({c_out8, sum8}), 32'd0);
        check("abort_state", 32'(st8), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        last8 = '0;
        stray = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done8) stray++;
        end
        check("abort_no_done", 32'(stray), 32'd0);
        run_op8(8'h12, 8'h34, 1'b0, 0);

        // Back-to-back with start held high.
        bb_a = '{8'h01, 8'h80, 8'hFE};
        bb_b = '{8'h01, 8'h80, 8'h00};
        bb_c = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) exp_q.push_back(ref8(bb_a[i], bb_b[i], bb_c[i]));
        start8 = 1'b1; a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0];
        accepted = 0; dones = 0; last_done = 0; prev_busy = busy8;
        for (int n = 0; n < 60 && dones < 3; n++) begin
            @(posedge clk); #1;
            if (busy8 && !prev_busy) begin
                accepted++;
                if (accepted < 3) begin
                    a8 = bb_a[accepted]; b8 = bb_b[accepted]; cin8 = bb_c[accepted];
                end else begin
                    start8 = 1'b0;
                end
            end
            if (done8) begin
                check("b2b_result", 32'({c_out8, sum8}), 32'(exp_q.pop_front()));
                if (dones > 0) check("b2b_spacing", 32'(cyc - last_done), 32'd10);
                last_done = cyc;
                dones++;
            end
            prev_busy = busy8;
        end
        start8 = 1'b0;
        check("b2b_done_count", 32'(dones), 32'd3);
        last8 = ref8(bb_a[2], bb_b[2], bb_c[2]);
        repeat (2) @(posedge clk);
        #1;

        // Random operands against the reference.
        repeat (16) run_op8(8'($urandom), 8'($urandom), 1'($urandom), 0);

        // Exhaustive sweep at WIDTH=3.
        for (int i = 0; i < 128; i++) begin
            a3 = 3'(i); b3 = 3'(i >> 3); cin3 = 1'(i >> 6);
            exp3 = ref3(a3, b3, cin3);
            start3 = 1'b1;
            @(posedge clk); #1;
            start3 = 1'b0;
            seen3 = 0;
            for (int n = 1; n <= 10 && !seen3; n++) begin
                @(posedge clk); #1;
                if (done3) seen3 = 1;
            end
            check("w3_done_seen", 32'(seen3), 32'd1);
            check("w3_result", 32'({c_out3, sum3}), 32'(exp3));
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
